int_ctrl: RTL and testbench
===========================

# int_ctrl

Prioritised, memory-mapped interrupt controller for the 8-bit computer. It latches rising edges from up to NSRC peripheral interrupt sources (UART RX, UART TX-done, timers), masks and prioritises them, and drives the CPU's single `int_req` line together with the winning source's vector. It sits on the same `rs_data`/`rd_data`/`mem_w_en` data-memory bus as the other MMIO peripherals. Its read mux output is merged into `mem_r_data` by the top level.

## Interface
Parameters:
- `NSRC`, 4 — number of interrupt sources, 1..8; index 0 has the highest priority.
- `BASE_ADDR`, 8'd240 — first MMIO address; the block decodes `BASE_ADDR` .. `BASE_ADDR+3+NSRC`.

Ports:
- `clock`  in  1  — single clock; all state changes on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `src_irq`  in  NSRC  — source request levels, synchronous to `clock`; the block responds to the rising edge.
- `addr`  in  8  — bus address (`rs_data`).
- `w_data`  in  8  — bus write data (`rd_data`).
- `w_en`  in  1  — bus write strobe (`mem_w_en`).
- `r_data`  out  8  — combinational register read data; 0 when the address does not hit.
- `r_hit`  out  1  — combinational; high when `addr` is inside the decoded window.
- `int_ack`  in  1  — one-cycle pulse from the CPU when it vectors to the interrupt.
- `int_req`  out  1  — interrupt request to the CPU, registered.
- `int_vec`  out  8  — vector of the requesting or in-service source, registered.

## Operation
Register map (byte offsets from `BASE_ADDR`):
- +0 MASK: read/write; bit i = 1 enables source i. Reset value 0. Bits ≥ NSRC read 0.
- +1 PEND: read; write-1-to-clear. Bit i is set by a rising edge on `src_irq[i]`.
- +2 STAT: read-only; {active, 4'b0, id[2:0]}. `active` = 1 in REQ or SERVICE.
- +3 EOI: write-only; any write ends service. Reads return 0.
- +4+i VEC[i]: read/write vector for source i. Reset value 0.

Edge detect:
- `prev_irq` is registered; `pend[i]` is set when `src_irq[i] & ~prev_irq[i]`.
- If a set and a clear hit the same bit in the same cycle, the set wins.

Prioritisation:
- `cand = pend & mask`; the winner is the lowest set index of `cand`.

FSM states: IDLE, REQ, SERVICE.
- IDLE → REQ when `cand != 0`. On entry, latch `id` = winner, `int_vec` = VEC[winner], and set `int_req` to 1.
- REQ → SERVICE on `int_ack`. Then clear `pend[id]` (a new edge in the same cycle wins) and drop `int_req`.
- REQ → IDLE when `pend[id] & mask[id]` becomes 0 before an ack (software cleared or masked the source). Drop `int_req`.
- A higher-priority source arriving in REQ does not preempt. `id` stays fixed until the ack.
- SERVICE → IDLE on an EOI write. There is no nesting: new pends accumulate and are arbitrated again from IDLE.
- `int_ack` outside REQ is ignored. EOI outside SERVICE is ignored.
- A VEC write to the latched `id` while in REQ does not change `int_vec`.

## Timing
- Reset (asynchronous, any state): FSM = IDLE; `int_req` = 0; `int_vec` = 0; `mask`, `pend`, `prev_irq`, `id` and VEC all 0. A request in flight is abandoned.
- Rising edge of `src_irq` sampled at edge k: `pend` is set after edge k. With the source enabled in IDLE, `int_req` goes high after edge k+1 (2-cycle latency).
- `int_ack` sampled at edge a: `int_req` goes low after edge a.
- EOI sampled at edge e: IDLE after edge e. A waiting candidate raises `int_req` after edge e+1.
- Register writes take effect at the clock edge. Reads are combinational from current state.

## Structure
- Package `int_ctrl_pkg` holds:
  - the offset localparams `OFS_MASK`, `OFS_PEND`, `OFS_STAT`, `OFS_EOI`, `OFS_VEC`;
  - the state encoding `ST_IDLE`, `ST_REQ`, `ST_SERVICE`.
- One sub-module, `int_prio_enc`: parameterised NSRC-to-index priority encoder with a `valid` output, purely combinational.
- Register file, edge detect and FSM live in `int_ctrl`.

## Test plan
- **Reset:** drive `reset_n` low mid-REQ → `int_req` = 0, `int_vec` = 0, all registers read 0 immediately. Release `reset_n` → the block stays idle.
- **Single source:** MASK = 8'h04, VEC[2] = 8'h40, pulse `src_irq[2]` → `int_req` high 2 cycles later with `int_vec` = 8'h40 and STAT = 8'h82. Then:
  - `int_ack` → `int_req` low and PEND bit 2 cleared;
  - EOI write → STAT = 8'h00.
- **Priority:** MASK = 8'h0F, edges on sources 1 and 3 in the same cycle → id = 1. After ack and EOI → `int_req` re-asserts with id = 3.
- **Masked pending:** MASK = 0, edge on source 0 → PEND = 8'h01 and `int_req` stays 0. Writing MASK = 8'h01 → `int_req` high the next cycle.
- **Cancel:** in REQ, write PEND = 8'h01 (clearing source 0) → FSM returns to IDLE and `int_req` drops the next cycle.
- **Boundary:** PEND clear and a new edge on the same bit in the same cycle → bit stays 1. Stray `int_ack` in IDLE and EOI in REQ → no state change.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared definitions for the interrupt controller.
//   OFS_*   : byte offsets of the MMIO registers relative to BASE_ADDR
//   state_e : controller FSM states (idle, request raised, in service)
package int_ctrl_pkg;

    localparam logic [7:0] OFS_MASK = 8'd0;
    localparam logic [7:0] OFS_PEND = 8'd1;
    localparam logic [7:0] OFS_STAT = 8'd2;
    localparam logic [7:0] OFS_EOI  = 8'd3;
    localparam logic [7:0] OFS_VEC  = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: combinational priority encoder, lowest set index wins.
//   req_i   in  NSRC : request vector (bit 0 = highest priority)
//   idx_o   out 3    : index of the winning request (0 when none)
//   valid_o out 1    : at least one request is set
module int_prio_enc #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req_i,
    output logic [2:0]      idx_o,
    output logic            valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (req_i[i] && !valid_o) begin
                idx_o   = 3'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: prioritised memory-mapped interrupt controller.
//   clock, reset_n : clock, asynchronous active-low reset
//   src_irq        : source request levels (rising edge latched into PEND)
//   addr/w_data/w_en : MMIO bus; r_data/r_hit combinational read port
//   int_ack        : CPU acknowledge pulse
//   int_req/int_vec: registered request line and vector of the current source
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int         NSRC      = 4,
    parameter logic [7:0] BASE_ADDR = 8'd240
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NSRC-1:0] src_irq,
    input  logic [7:0]      addr,
    input  logic [7:0]      w_data,
    input  logic            w_en,
    output logic [7:0]      r_data,
    output logic            r_hit,
    input  logic            int_ack,
    output logic            int_req,
    output logic [7:0]      int_vec
);

    localparam logic [7:0] WIN_SIZE = 8'(4 + NSRC);

    state_e          state_q, state_d;
    logic [2:0]      id_q, id_d;
    logic            req_q, req_d;
    logic [7:0]      vout_q, vout_d;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] prev_q;
    logic [7:0]      vec_q [NSRC];

    logic [7:0]      ofs;
    logic [2:0]      vidx;
    logic            wr, wr_mask, wr_pend, wr_eoi, wr_vec;
    logic [NSRC-1:0] rise, cand;
    logic [2:0]      win;
    logic            win_vld;
    logic            cur_live;
    logic [7:0]      win_vec;
    logic            ack_clr;

    // Offset arithmetic wraps modulo 256, so the window test is a single compare.
    assign ofs     = addr - BASE_ADDR;
    assign vidx    = 3'(ofs - OFS_VEC);
    assign r_hit   = (ofs < WIN_SIZE);
    assign wr      = w_en && r_hit;
    assign wr_mask = wr && (ofs == OFS_MASK);
    assign wr_pend = wr && (ofs == OFS_PEND);
    assign wr_eoi  = wr && (ofs == OFS_EOI);
    assign wr_vec  = wr && (ofs >= OFS_VEC);

    assign rise = src_irq & ~prev_q;
    assign cand = pend_q & mask_q;

    int_prio_enc #(.NSRC(NSRC)) u_prio_enc (
        .req_i   (cand),
        .idx_o   (win),
        .valid_o (win_vld)
    );

    // Index-by-loop keeps the 3-bit ids legal for any NSRC.
    always_comb begin
        cur_live = 1'b0;
        win_vec  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (3'(i) == id_q) cur_live = cand[i];
            if (3'(i) == win)  win_vec  = vec_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        req_d   = req_q;
        vout_d  = vout_q;
        ack_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_REQ;
                    id_d    = win;
                    vout_d  = win_vec;
                    req_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d = ST_SERVICE;
                    req_d   = 1'b0;
                    ack_clr = 1'b1;
                end else if (!cur_live) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clears are applied first so a same-cycle rising edge always survives.
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) pend_d = pend_d & ~w_data[NSRC-1:0];
        if (ack_clr) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (3'(i) == id_q) pend_d[i] = 1'b0;
            end
        end
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
            vout_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= req_d;
            vout_q  <= vout_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
            for (int unsigned i = 0; i < NSRC; i++) vec_q[i] <= '0;
        end else begin
            prev_q <= src_irq;
            pend_q <= pend_d;
            if (wr_mask) mask_q <= w_data[NSRC-1:0];
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (wr_vec && (vidx == 3'(i))) vec_q[i] <= w_data;
            end
        end
    end

    // STAT reports the id only while a request or service is active.
    always_comb begin
        r_data = '0;
        if (r_hit) begin
            if (ofs == OFS_MASK)      r_data = 8'(mask_q);
            else if (ofs == OFS_PEND) r_data = 8'(pend_q);
            else if (ofs == OFS_STAT) r_data = (state_q != ST_IDLE) ? {1'b1, 4'b0000, id_q} : '0;
            else if (ofs >= OFS_VEC) begin
                for (int unsigned i = 0; i < NSRC; i++) begin
                    if (vidx == 3'(i)) r_data = vec_q[i];
                end
            end
        end
    end

    assign int_req = req_q;
    assign int_vec = vout_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    localparam int         NSRC = 4;
    localparam logic [7:0] BASE = 8'd240;
    localparam logic [7:0] SRC_MSK = 8'h0F;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [NSRC-1:0] src_irq = '0;
    logic [7:0]      addr = '0;
    logic [7:0]      w_data = '0;
    logic            w_en = 1'b0;
    logic            int_ack = 1'b0;
    logic [7:0]      r_data;
    logic            r_hit;
    logic            int_req;
    logic [7:0]      int_vec;

    int_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .src_irq (src_irq),
        .addr    (addr),
        .w_data  (w_data),
        .w_en    (w_en),
        .r_data  (r_data),
        .r_hit   (r_hit),
        .int_ack (int_ack),
        .int_req (int_req),
        .int_vec (int_vec)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: registers as plain bytes, controller as two flags.
    logic [7:0]      m_mask, m_pend, m_vout;
    logic [7:0]      m_vec [8];
    logic [NSRC-1:0] m_prev;
    bit              m_waiting, m_serving;
    int              m_id;

    task automatic model_reset();
        m_mask = '0; m_pend = '0; m_vout = '0; m_prev = '0;
        for (int i = 0; i < 8; i++) m_vec[i] = '0;
        m_waiting = 0; m_serving = 0; m_id = 0;
    endtask

    task automatic model_step();
        logic [7:0] o, rise, np, nm;
        bit wr;
        int w;
        o = addr - BASE;
        wr = w_en && (o < 8'(4 + NSRC));
        rise = 8'(src_irq & ~m_prev);
        np = m_pend;
        nm = m_mask;
        if (!m_waiting && !m_serving) begin
            w = -1;
            for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) w = i;
            if (w >= 0) begin m_waiting = 1; m_id = w; m_vout = m_vec[w]; end
        end else if (m_waiting) begin
            if (int_ack) begin m_waiting = 0; m_serving = 1; np[m_id] = 1'b0; end
            else if (!(m_pend[m_id] && m_mask[m_id])) m_waiting = 0;
        end else if (wr && o == OFS_EOI) begin
            m_serving = 0;
        end
        if (wr && o == OFS_MASK) nm = w_data & SRC_MSK;
        if (wr && o == OFS_PEND) np = np & ~w_data;
        if (wr && o >= OFS_VEC) m_vec[o - 4] = w_data;
        m_pend = np | rise;
        m_mask = nm;
        m_prev = src_irq;
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        logic [7:0] o;
        o = a - BASE;
        if (o >= 8'(4 + NSRC)) return 8'h00;
        if (o == OFS_MASK) return m_mask;
        if (o == OFS_PEND) return m_pend;
        if (o == OFS_STAT) return (m_waiting || m_serving) ? (8'h80 | 8'(m_id)) : 8'h00;
        if (o == OFS_EOI) return 8'h00;
        return m_vec[o - 4];
    endfunction

    task automatic tick();
        if (!reset_n) model_reset(); else model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_wr(input logic [7:0] o, input logic [7:0] d);
        addr = BASE + o; w_data = d; w_en = 1'b1;
        tick();
        w_en = 1'b0;
    endtask

    task automatic set_rd(input logic [7:0] o);
        addr = BASE + o;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", int_req); end
        n_cmp++; if (int_vec !== 8'h00) begin n_bad++; $display("FAIL reset_vec got %h want 00", int_vec); end
        for (int o = 0; o < NSRC + 4; o++) begin
            set_rd(8'(o));
            n_cmp++; if (r_data !== 8'h00 || r_hit !== 1'b1) begin n_bad++; $display("FAIL reset_rd ofs %0d got %h/%b want 00/1", o, r_data, r_hit); end
        end
        addr = BASE - 8'd1;
        #1;
        n_cmp++; if (r_hit !== 1'b0 || r_data !== 8'h00) begin n_bad++; $display("FAIL miss_rd got %h/%b want 00/0", r_data, r_hit); end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset got %b want 0", int_req); end
    endtask

    task automatic test_single();
        bus_wr(OFS_MASK, 8'h04);
        bus_wr(OFS_VEC + 8'd2, 8'h40);
        src_irq = 4'b0100;
        tick();
        src_irq = '0;
        set_rd(OFS_PEND);
        n_cmp++; if (int_req !== 1'b0 || r_data !== 8'h04) begin n_bad++; $display("FAIL single_k req/pend got %b/%h want 0/04", int_req, r_data); end
        tick();
        set_rd(OFS_STAT);
        n_cmp++; if (int_req !== 1'b1 || int_vec !== 8'h40) begin n_bad++; $display("FAIL single_req got %b/%h want 1/40", int_req, int_vec); end
        n_cmp++; if (r_data !== 8'h82) begin n_bad++; $display("FAIL single_stat got %h want 82", r_data); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        set_rd(OFS_PEND);
        n_cmp++; if (int_req !== 1'b0 || r_data !== 8'h00) begin n_bad++; $display("FAIL single_ack req/pend got %b/%h want 0/00", int_req, r_data); end
        bus_wr(OFS_EOI, 8'h00);
        set_rd(OFS_STAT);
        n_cmp++; if (r_data !== 8'h00) begin n_bad++; $display("FAIL single_eoi stat got %h want 00", r_data); end
    endtask

    task automatic test_priority();
        bus_wr(OFS_VEC + 8'd1, 8'h11);
        bus_wr(OFS_VEC + 8'd3, 8'h33);
        bus_wr(OFS_MASK, 8'h0F);
        src_irq = 4'b1010;
        tick();
        src_irq = '0;
        tick();
        set_rd(OFS_STAT);
        n_cmp++; if (r_data !== 8'h81 || int_vec !== 8'h11 || int_req !== 1'b1) begin n_bad++; $display("FAIL prio_first stat/vec/req got %h/%h/%b want 81/11/1", r_data, int_vec, int_req); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        bus_wr(OFS_EOI, 8'h00);
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL prio_eoi req got %b want 0", int_req); end
        tick();
        set_rd(OFS_STAT);
        n_cmp++; if (r_data !== 8'h83 || int_vec !== 8'h33 || int_req !== 1'b1) begin n_bad++; $display("FAIL prio_second stat/vec/req got %h/%h/%b want 83/33/1", r_data, int_vec, int_req); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        bus_wr(OFS_EOI, 8'h00);
    endtask

    task automatic test_masked_and_cancel();
        bus_wr(OFS_MASK, 8'h00);
        src_irq = 4'b0001;
        tick();
        src_irq = '0;
        tick();
        set_rd(OFS_PEND);
        n_cmp++; if (r_data !== 8'h01 || int_req !== 1'b0) begin n_bad++; $display("FAIL masked pend/req got %h/%b want 01/0", r_data, int_req); end
        bus_wr(OFS_MASK, 8'h01);
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL unmask_edge req got %b want 0", int_req); end
        tick();
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL unmask_req got %b want 1", int_req); end
        bus_wr(OFS_PEND, 8'h01);
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL cancel_edge req got %b want 1", int_req); end
        tick();
        set_rd(OFS_STAT);
        n_cmp++; if (int_req !== 1'b0 || r_data !== 8'h00) begin n_bad++; $display("FAIL cancel req/stat got %b/%h want 0/00", int_req, r_data); end
    endtask

    task automatic test_boundary();
        bus_wr(OFS_MASK, 8'h00);
        src_irq = 4'b0010;
        tick();
        src_irq = '0;
        tick();
        addr = BASE + OFS_PEND; w_data = 8'h02; w_en = 1'b1; src_irq = 4'b0010;
        tick();
        w_en = 1'b0; src_irq = '0;
        set_rd(OFS_PEND);
        n_cmp++; if (r_data !== 8'h02) begin n_bad++; $display("FAIL set_wins pend got %h want 02", r_data); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        set_rd(OFS_STAT);
        n_cmp++; if (r_data !== 8'h00 || int_req !== 1'b0) begin n_bad++; $display("FAIL stray_ack stat/req got %h/%b want 00/0", r_data, int_req); end
        set_rd(OFS_PEND);
        n_cmp++; if (r_data !== 8'h02) begin n_bad++; $display("FAIL stray_ack pend got %h want 02", r_data); end
        bus_wr(OFS_MASK, 8'h02);
        tick();
        bus_wr(OFS_EOI, 8'h00);
        set_rd(OFS_STAT);
        n_cmp++; if (r_data !== 8'h81 || int_req !== 1'b1) begin n_bad++; $display("FAIL eoi_in_req stat/req got %h/%b want 81/1", r_data, int_req); end
        bus_wr(OFS_VEC + 8'd1, 8'h77);
        n_cmp++; if (int_vec !== 8'h11) begin n_bad++; $display("FAIL vec_write_in_req got %h want 11", int_vec); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        bus_wr(OFS_EOI, 8'h00);
    endtask

    task automatic test_reset_midreq();
        bus_wr(OFS_VEC, 8'h5A);
        bus_wr(OFS_MASK, 8'h01);
        src_irq = 4'b0001;
        tick();
        src_irq = '0;
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vec !== 8'h5A) begin n_bad++; $display("FAIL pre_reset req/vec got %b/%h want 1/5a", int_req, int_vec); end
        reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (int_req !== 1'b0 || int_vec !== 8'h00) begin n_bad++; $display("FAIL async_reset req/vec got %b/%h want 0/00", int_req, int_vec); end
        for (int o = 0; o < NSRC + 4; o++) begin
            set_rd(8'(o));
            n_cmp++; if (r_data !== 8'h00) begin n_bad++; $display("FAIL async_reset_rd ofs %0d got %h want 00", o, r_data); end
        end
        reset_n = 1'b1;
        repeat (3) tick();
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL post_reset req got %b want 0", int_req); end
    endtask

    task automatic test_random();
        logic [7:0] ra;
        for (int c = 0; c < 600; c++) begin
            src_irq = NSRC'($urandom & $urandom & $urandom);
            w_en = ($urandom_range(0, 3) == 0);
            addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, NSRC + 3));
            w_data = 8'($urandom);
            int_ack = ($urandom_range(0, 2) == 0);
            tick();
            n_cmp++; if (int_req !== 1'(m_waiting)) begin n_bad++; $display("FAIL rnd_req cyc %0d got %b want %b", c, int_req, m_waiting); end
            n_cmp++; if (int_vec !== m_vout) begin n_bad++; $display("FAIL rnd_vec cyc %0d got %h want %h", c, int_vec, m_vout); end
            ra = BASE + 8'($urandom_range(0, NSRC + 5));
            addr = ra;
            #1;
            n_cmp++; if (r_data !== model_rd(ra)) begin n_bad++; $display("FAIL rnd_rd cyc %0d addr %0d got %h want %h", c, ra, r_data, model_rd(ra)); end
        end
        src_irq = '0; w_en = 1'b0; int_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masked_and_cancel();
        test_boundary();
        test_reset_midreq();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
